// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the multicycle datapath; 2-5 cycles per instruction, strobes combinational from state.
// Backpressure: define MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR until mem_ready=1; otherwise mem_ready is ignored.
module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
  input  logic               cond_ex,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               ir_en,
  output logic               reg_we,
  output logic               mem_we,
  output logic               adr_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic               alu_op,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_mem_go;
  logic w_pc_en;
  logic w_ir_en;
  logic w_reg_we;
  logic w_mem_we;
  logic w_unused;

`ifdef MEM_WAIT_EN
  assign w_mem_go = mem_ready;
  assign w_unused = &{1'b0, funct[4:1]};
`else
  assign w_mem_go = 1'b1;
  assign w_unused = &{1'b0, funct[4:1], mem_ready};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    w_pc_en    = 1'b0;
    w_ir_en    = 1'b0;
    w_reg_we   = 1'b0;
    w_mem_we   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_en    = w_mem_go;
        w_pc_en    = w_mem_go;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_next     = w_mem_go ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b00:   w_next = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        w_next    = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        w_next  = w_mem_go ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        w_reg_we   = cond_ex;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        adr_src  = 1'b1;
        w_mem_we = cond_ex & w_mem_go;
        w_next   = w_mem_go ? S_FETCH : S_MEMWR;
      end
      S_EXECR: begin
        alu_op = 1'b1;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_we = cond_ex;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        w_pc_en    = cond_ex;
        w_next     = S_FETCH;
      end
      // Encodings 10-15 are unreachable; recover to FETCH with every output at 0.
      default: w_next = S_FETCH;
    endcase
  end

  assign pc_en   = w_pc_en  & ~reset;
  assign ir_en   = w_ir_en  & ~reset;
  assign reg_we  = w_reg_we & ~reset;
  assign mem_we  = w_mem_we & ~reset;
  assign state_o = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomised instruction stream checked against an instruction-level expected-cycle model.
module tb_multicycle_ctrl_fsm;

`ifdef MEM_WAIT_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                         ALUWB = 4'd8, BRANCH = 4'd9;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic       cond_ex;
  logic       mem_ready;
  logic       pc_en, ir_en, reg_we, mem_we, adr_src, alu_op;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] state_o;

  multicycle_ctrl_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .cond_ex(cond_ex),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_en(ir_en), .reg_we(reg_we),
    .mem_we(mem_we), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // One expected clock cycle: inputs to drive and outputs required.
  typedef struct {
    logic [3:0] st;
    logic [1:0] op;
    logic [5:0] f;
    logic       cex;
    logic       mrdy;
    logic [3:0] en;   // {pc_en, ir_en, reg_we, mem_we}
    logic [7:0] sel;  // {adr_src, alu_src_a, alu_src_b, result_src, alu_op}
  } cyc_t;

  cyc_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic cyc_t mk(input logic [3:0] st, input logic [1:0] o, input logic [5:0] f,
                              input logic cex, input logic mrdy);
    cyc_t c;
    logic go, pc, ir, rw, mw, adr, aop;
    logic [1:0] a, b, rs;
    go  = WAIT ? mrdy : 1'b1;
    pc  = (st == FETCH && go) || (st == BRANCH && cex);
    ir  = (st == FETCH && go);
    rw  = (st == MEMWB || st == ALUWB) && cex;
    mw  = (st == MEMWR) && cex && go;
    adr = (st == MEMRD || st == MEMWR);
    a   = (st == FETCH || st == DECODE) ? 2'd1 : 2'd0;
    b   = (st == FETCH || st == DECODE) ? 2'd2 :
          (st == MEMADR || st == EXECI || st == BRANCH) ? 2'd1 : 2'd0;
    rs  = (st == FETCH || st == DECODE || st == BRANCH) ? 2'd2 :
          (st == MEMWB) ? 2'd1 : 2'd0;
    aop = (st == EXECR || st == EXECI);
    c.st = st; c.op = o; c.f = f; c.cex = cex; c.mrdy = mrdy;
    c.en  = {pc, ir, rw, mw};
    c.sel = {adr, a, b, rs, aop};
    return c;
  endfunction

  // Unsampled cycles get junk op/funct, which must have no effect.
  task automatic push(input logic [3:0] st, input logic [1:0] o, input logic [5:0] f, input bit waited);
    if (WAIT && waited) begin
      repeat ($urandom_range(0, 2)) q.push_back(mk(st, 2'($urandom), 6'($urandom), 1'($urandom), 1'b0));
      q.push_back(mk(st, o, f, 1'($urandom), 1'b1));
    end else begin
      q.push_back(mk(st, o, f, 1'($urandom), 1'($urandom)));
    end
  endtask

  task automatic build_instr(input logic [1:0] o, input logic [5:0] f);
    push(FETCH, 2'($urandom), 6'($urandom), 1'b1);
    push(DECODE, o, f, 1'b0);
    case (o)
      2'b00: begin
        push(f[5] ? EXECI : EXECR, 2'($urandom), 6'($urandom), 1'b0);
        push(ALUWB, 2'($urandom), 6'($urandom), 1'b0);
      end
      2'b01: begin
        push(MEMADR, 2'($urandom), f, 1'b0);
        if (f[0]) begin
          push(MEMRD, 2'($urandom), 6'($urandom), 1'b1);
          push(MEMWB, 2'($urandom), 6'($urandom), 1'b0);
        end else begin
          push(MEMWR, 2'($urandom), 6'($urandom), 1'b1);
        end
      end
      2'b10: push(BRANCH, 2'($urandom), 6'($urandom), 1'b0);
      default: ;
    endcase
  endtask

  // Entered and left at posedge+1.
  task automatic drain();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      op = c.op; funct = c.f; cond_ex = c.cex; mem_ready = c.mrdy;
      @(negedge clk);
      chk("state", 32'(state_o), 32'(c.st));
      chk("enables", 32'({pc_en, ir_en, reg_we, mem_we}), 32'(c.en));
      chk("selects", 32'({adr_src, alu_src_a, alu_src_b, result_src, alu_op}), 32'(c.sel));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; op = 2'b00; funct = 6'd0; cond_ex = 1'b1; mem_ready = 1'b1;
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_en", 32'({pc_en, ir_en, reg_we, mem_we}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_en", 32'({pc_en, ir_en, reg_we, mem_we}), 32'd0);
    chk("rst_hold_sel", 32'({adr_src, alu_src_a, alu_src_b, result_src, alu_op}), 32'b0_01_10_10_0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Fixed load/store/data/branch/undefined sequences, then random ones.
    build_instr(2'b01, 6'b000001); drain();
    build_instr(2'b01, 6'b000000); drain();
    build_instr(2'b00, 6'b100000); drain();
    build_instr(2'b00, 6'b000000); drain();
    build_instr(2'b10, 6'b000000); drain();
    build_instr(2'b11, 6'b000000); drain();
    for (int i = 0; i < 150; i++) begin
      build_instr(2'($urandom), 6'($urandom));
      drain();
    end

    // Abort mid-EXECR with an asynchronous reset.
    build_instr(2'b00, 6'b000000);
    void'(q.pop_back());
    void'(q.pop_back());
    drain();
    op = 2'b00; funct = 6'd0; cond_ex = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("pre_abort_state", 32'(state_o), 32'(EXECR));
    #1 reset = 1'b1;
    #1;
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_en", 32'({pc_en, ir_en, reg_we, mem_we}), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_hold_state", 32'(state_o), 32'd0);
    chk("abort_hold_en", 32'({pc_en, ir_en, reg_we, mem_we}), 32'd0);
    reset = 1'b0;
    #1;
    chk("release_en", 32'({pc_en, ir_en}), 32'b11);
    @(posedge clk);
    #1;
    chk("release_next", 32'(state_o), 32'(DECODE));
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 100; i++) begin
      build_instr(2'($urandom), 6'($urandom));
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle datapath.
- Generates the write-enable strobes (pc_en, ir_en) that drive the enabled, resettable 32-bit datapath registers (PC, instruction register), plus register-file/memory write strobes and mux selects.
- Sits directly upstream of those registers.
- Moore machine; outputs decode from the current state only, except the cond_ex gating.

Parameters:
- STATE_W, 4, width of state encoding and of the state_o debug port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  2  instruction class: 00 data-proc, 01 memory, 10 branch, 11 undefined.
- funct  in  6  funct[5]=immediate (data-proc), funct[0]=load (memory; 1=LDR, 0=STR).
- cond_ex  in  1  condition-check result for the current instruction.
- mem_ready  in  1  memory handshake; used only under MEM_WAIT_EN.
- pc_en  out  1  PC register enable.
- ir_en  out  1  instruction register enable.
- reg_we  out  1  register-file write.
- mem_we  out  1  data-memory write.
- adr_src  out  1  0=PC, 1=ALU result, as memory address.
- alu_src_a  out  2  ALU A select: 0=reg A, 1=PC.
- alu_src_b  out  2  ALU B select: 00=reg B, 01=imm, 10=const 4.
- result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result.
- alu_op  out  1  1 = ALU decoder uses funct; 0 = add.
- state_o  out  STATE_W  current state encoding, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10-15 return to FETCH on the next edge, with all enables 0.
- Reset:
  - state=FETCH immediately (asynchronous).
  - While reset=1, pc_en, ir_en, reg_we and mem_we are forced 0.
  - Selects show the FETCH values.
  - On the first edge after deassertion, FETCH executes normally.
- Defaults: any output not listed for a state is 0.
- FETCH:
  - Outputs: ir_en=1, pc_en=1, adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10.
  - Next state: DECODE.
- DECODE:
  - Outputs: alu_src_a=1, alu_src_b=10, result_src=10.
  - Next state by op/funct:
    - op=01 -> MEMADR.
    - op=00 & funct[5]=0 -> EXECR.
    - op=00 & funct[5]=1 -> EXECI.
    - op=10 -> BRANCH.
    - op=11 -> FETCH (no architectural writes).
- MEMADR:
  - Outputs: alu_src_b=01.
  - Next state: funct[0]=1 -> MEMRD, else MEMWR.
- MEMRD:
  - Outputs: adr_src=1.
  - Next state: MEMWB.
- MEMWB:
  - Outputs: result_src=01, reg_we=cond_ex.
  - Next state: FETCH.
- MEMWR:
  - Outputs: adr_src=1, mem_we=cond_ex.
  - Next state: FETCH.
- EXECR:
  - Outputs: alu_src_b=00, alu_op=1.
  - Next state: ALUWB.
- EXECI:
  - Outputs: alu_src_b=01, alu_op=1.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: result_src=00, reg_we=cond_ex.
  - Next state: FETCH.
- BRANCH:
  - Outputs: alu_src_b=01, result_src=10, pc_en=cond_ex.
  - Next state: FETCH.
- Latency (cycles, including FETCH):
  - Load: 5.
  - Store: 4.
  - Data-proc: 4.
  - Branch: 3.
  - Undefined: 2.
- op/funct are sampled only in DECODE and MEMADR; changes in other states have no effect.
- Reset asserted mid-instruction aborts it: no pending write strobe is issued; restart at FETCH.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - In FETCH, MEMRD and MEMWR, the state holds while mem_ready=0.
  - ir_en/pc_en (FETCH) and mem_we (MEMWR) assert only in the cycle mem_ready=1.
  - Transition occurs on that edge.
- Undefined: mem_ready is ignored; timing is exactly as in Behaviour.

Test Plan:
- Reset: reset=1 mid-EXECR -> state_o=0 with no clock edge; pc_en=ir_en=reg_we=mem_we=0 while reset high. Release reset -> next cycle in FETCH with ir_en=1, pc_en=1.
- Load sequence: op=01, funct=6'b000001, cond_ex=1 -> state_o 0,1,2,3,4,0. reg_we=1 only in state 4, with result_src=01. Second FETCH follows on cycle 6.
- Store sequence: op=01, funct=0, cond_ex=1 -> states 0,1,2,5,0; mem_we=1, adr_src=1 in state 5. Repeat with cond_ex=0 -> mem_we stays 0.
- Data-proc: funct=6'b100000 -> 0,1,7,8,0 with alu_src_b=01, alu_op=1 in EXECI. funct=0 -> EXECR with alu_src_b=00.
- Branch: op=10, cond_ex=1 -> pc_en=1 in states 0 and 9. cond_ex=0 -> pc_en=1 in state 0 only. op=11 -> 0,1,0 with no reg_we/mem_we.
- MEM_WAIT_EN: hold mem_ready=0 for 3 cycles in FETCH -> state_o=0 held, ir_en=pc_en=0 for those cycles. mem_ready=1 -> ir_en=pc_en=1 for one cycle, then DECODE.
